// File: rtl/datapath_mem_responder_if.sv
// Bundles for the responder: datapath request/hit signals and the word-wide RAM port.
// Each bundle has a master (initiator) view and a slave (responder) view.

interface datapath_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              halt;
    logic              ihit;
    logic [DATA_W-1:0] imemload;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              flushed;

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ihit, imemload, dhit, dmemload, flushed
    );

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ihit, imemload, dhit, dmemload, flushed
    );
endinterface

interface ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramready
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramready
    );
endinterface

// File: rtl/datapath_mem_responder.sv
// Stand-in for the I/D caches: arbitrates fetches and data accesses onto one RAM port,
// data first, with a one-entry fetch buffer so a repeated fetch hits with zero latency.

module datapath_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    datapath_cache_if.slave  dcif,
    ram_if.master            ramif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DACCESS = 2'd1,
        IFETCH  = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              ibuf_valid_q, ibuf_valid_d;
    logic [ADDR_W-1:2] ibuf_addr_q,  ibuf_addr_d;
    logic [DATA_W-1:0] ibuf_data_q,  ibuf_data_d;
    logic [DATA_W-1:0] dload_q,      dload_d;
    logic              d_done_q,     d_done_d;

    logic              dpend;
    logic              ibuf_match;
    logic              ibuf_dmatch;

    logic              ihit;
    logic              dhit;
    logic              flushed;
    logic [DATA_W-1:0] imemload;
    logic [DATA_W-1:0] dmemload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;

    // Byte-offset bits of request addresses play no part in word accesses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{dcif.imemaddr[1:0], dcif.dmemaddr[1:0]};

    // A data request already answered stays answered until the pipeline advances (ihit).
    assign dpend       = (dcif.dmemREN | dcif.dmemWEN) & ~d_done_q;
    assign ibuf_match  = ibuf_valid_q & (ibuf_addr_q == dcif.imemaddr[ADDR_W-1:2]);
    assign ibuf_dmatch = ibuf_valid_q & (ibuf_addr_q == dcif.dmemaddr[ADDR_W-1:2]);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dcif.halt && !dpend) begin
                    state_d = HALTED;
                end else if (dpend) begin
                    state_d = DACCESS;
                end else if (dcif.imemREN && !ibuf_match) begin
                    state_d = IFETCH;
                end
            end
            DACCESS: begin
                if (ramif.ramready) begin
                    state_d = IDLE;
                end
            end
            IFETCH: begin
                if (ramif.ramready) begin
                    state_d = IDLE;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit      = 1'b0;
        dhit      = 1'b0;
        flushed   = 1'b0;
        imemload  = ibuf_data_q;
        dmemload  = dload_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        case (state_q)
            IDLE: begin
                // Buffer hit only when nothing of higher priority claims this cycle.
                ihit = dcif.imemREN & ibuf_match & ~dcif.halt & ~dpend;
            end
            DACCESS: begin
                ram_ren   = dcif.dmemREN;
                ram_wen   = dcif.dmemWEN;
                ram_addr  = {dcif.dmemaddr[ADDR_W-1:2], 2'b00};
                ram_store = dcif.dmemstore;
                dhit      = ramif.ramready;
                dmemload  = ramif.ramload;
            end
            IFETCH: begin
                ram_ren  = 1'b1;
                ram_addr = {dcif.imemaddr[ADDR_W-1:2], 2'b00};
                ihit     = ramif.ramready;
                imemload = ramif.ramload;
            end
            HALTED: begin
                flushed = 1'b1;
            end
            default: begin
                flushed = 1'b0;
            end
        endcase
    end

    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_data_d  = ibuf_data_q;
        dload_d      = dload_q;
        d_done_d     = d_done_q;

        if (state_q == IFETCH && ramif.ramready) begin
            ibuf_valid_d = 1'b1;
            ibuf_addr_d  = dcif.imemaddr[ADDR_W-1:2];
            ibuf_data_d  = ramif.ramload;
        end

        // A store to the buffered word makes the buffered instruction stale.
        if (state_q == DACCESS && dcif.dmemWEN && ibuf_dmatch) begin
            ibuf_valid_d = 1'b0;
        end

        if (state_q == DACCESS && ramif.ramready) begin
            dload_d  = ramif.ramload;
            d_done_d = 1'b1;
        end

        if (ihit) begin
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= '0;
            ibuf_data_q  <= '0;
            dload_q      <= '0;
            d_done_q     <= 1'b0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_data_q  <= ibuf_data_d;
            dload_q      <= dload_d;
            d_done_q     <= d_done_d;
        end
    end

    assign dcif.ihit      = ihit;
    assign dcif.imemload  = imemload;
    assign dcif.dhit      = dhit;
    assign dcif.dmemload  = dmemload;
    assign dcif.flushed   = flushed;
    assign ramif.ramREN   = ram_ren;
    assign ramif.ramWEN   = ram_wen;
    assign ramif.ramaddr  = ram_addr;
    assign ramif.ramstore = ram_store;

endmodule
